serial_subtractor: RTL and testbench

- Bit-serial ripple subtractor. Computes diff = a - b - bin, LSB first, one full-subtractor bit per clock, with a single borrow flop.
- It is the inverse-direction counterpart to the team's full-adder arithmetic cells and trades area for latency in narrow-datapath arithmetic.
- Operands come in, and results go out, over valid/ready handshakes.

---
 rtl/serial_subtractor.sv | 128 ++++++++++++
 tb/tb_serial_subtractor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one full-subtractor bit per clock, LSB first.
// Operands are accepted and results returned over valid/ready handshakes, one operation at a time.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt_reg;
    logic             borrow_reg;
    logic             sa_reg;
    logic             sb_reg;
    logic             bout_reg;
    logic             ovf_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;

    logic             x_bit;
    logic             y_bit;
    logic             d_bit;
    logic             br_next;
    logic             last_bit;

    assign x_bit    = a_sh_reg[0];
    assign y_bit    = b_sh_reg[0];
    assign d_bit    = x_bit ^ y_bit ^ borrow_reg;
    assign br_next  = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_reg);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    // Result fills from the MSB side so bit i settles at position i after WIDTH shifts.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_res_shift
            assign res_next[gi] = res_reg[gi + 1];
        end
    endgenerate
    assign res_next[WIDTH-1] = d_bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            res_reg       <= '0;
            cnt_reg       <= '0;
            borrow_reg    <= 1'b0;
            sa_reg        <= 1'b0;
            sb_reg        <= 1'b0;
            bout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        state_reg    <= RUN;
                        a_sh_reg     <= a;
                        b_sh_reg     <= b;
                        borrow_reg   <= bin;
                        cnt_reg      <= '0;
                        sa_reg       <= a[WIDTH-1];
                        sb_reg       <= b[WIDTH-1];
                        in_ready_reg <= 1'b0;
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh_reg   <= a_sh_reg >> 1;
                    b_sh_reg   <= b_sh_reg >> 1;
                    res_reg    <= res_next;
                    borrow_reg <= br_next;
                    cnt_reg    <= cnt_reg + CW'(1);
                    if (last_bit) begin
                        state_reg     <= DONE;
                        out_valid_reg <= 1'b1;
                        bout_reg      <= br_next;
                        // d_bit here is the final result MSB.
                        ovf_reg       <= (sa_reg != sb_reg) && (d_bit != sa_reg);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign diff      = res_reg;
    assign bout      = bout_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8-bit instance for the main vectors and
// handshake corners, plus a 1-bit instance for the minimum-width latency case.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       bin = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] diff;
    logic       bout;
    logic       ovf;

    logic       w1_in_valid = 1'b0;
    logic       w1_in_ready;
    logic [0:0] w1_a = '0;
    logic [0:0] w1_b = '0;
    logic       w1_bin = 1'b0;
    logic       w1_out_valid;
    logic       w1_out_ready = 1'b1;
    logic [0:0] w1_diff;
    logic       w1_bout;
    logic       w1_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .ovf(ovf)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w1_in_valid), .in_ready(w1_in_ready),
        .a(w1_a), .b(w1_b), .bin(w1_bin),
        .out_valid(w1_out_valid), .out_ready(w1_out_ready),
        .diff(w1_diff), .bout(w1_bout), .ovf(w1_ovf)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       ovf;
        string      name;
    } vec_t;

    typedef struct {
        logic a;
        logic b;
        logic bin;
        logic diff;
        logic bout;
        logic ovf;
    } vec1_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Waits (bounded) for in_ready, accepts one operand set, checks latency, result and handoff.
    task automatic do_op(input vec_t v);
        int waitc;
        int lat;
        waitc = 0;
        while (!in_ready && waitc < 40) begin
            @(negedge clk);
            waitc++;
        end
        check({v.name, " in_ready before accept"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({v.name, " latency"}, 32'(lat), 32'd8);
        check({v.name, " diff"}, 32'(diff), 32'(v.diff));
        check({v.name, " bout"}, 32'(bout), 32'(v.bout));
        check({v.name, " ovf"}, 32'(ovf), 32'(v.ovf));
        @(posedge clk); #1;
        check({v.name, " out_valid after handoff"}, 32'(out_valid), 32'd0);
        check({v.name, " in_ready after handoff"}, 32'(in_ready), 32'd1);
        $display("op %s: a=0x%02h b=0x%02h bin=%0d -> diff=0x%02h bout=%0d ovf=%0d lat=%0d",
                 v.name, v.a, v.b, v.bin, diff, bout, ovf, lat);
    endtask

    vec_t  vecs [10];
    vec1_t vecs1 [3];

    initial begin
        vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "5-3"};
        vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, "3-5"};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "80-01"};
        vecs[3] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, "7F-FF"};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "0-0-1"};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "FF-FF-1"};
        vecs[6] = '{8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1, "00-80"};
        vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, "AA-55"};
        vecs[8] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 1'b1, "80-7F-1"};
        vecs[9] = '{8'h64, 8'h32, 1'b0, 8'h32, 1'b0, 1'b0, "64-32"};

        vecs1[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs1[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset state
        #12;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset diff", 32'(diff), 32'd0);
        check("reset bout", 32'(bout), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after reset release", 32'(in_ready), 32'd1);

        // Table-driven vectors, out_ready held high throughout (also covers out_ready outside DONE)
        for (int i = 0; i < 10; i++) do_op(vecs[i]);

        // Backpressure with in_valid high and changing operands
        begin
            int lat;
            @(negedge clk);
            out_ready = 1'b0;
            a = 8'h20; b = 8'h08; bin = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 0;
            while (!out_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            check("bp latency", 32'(lat), 32'd8);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                a = 8'(8'h31 + 8'(c)); b = 8'(8'h07 * 8'(c + 1)); bin = c[0]; in_valid = 1'b1;
                @(posedge clk); #1;
                check("bp out_valid held", 32'(out_valid), 32'd1);
                check("bp in_ready low", 32'(in_ready), 32'd0);
                check("bp diff stable", 32'(diff), 32'h18);
                check("bp bout stable", 32'(bout), 32'd0);
                check("bp ovf stable", 32'(ovf), 32'd0);
                $display("bp cycle %0d: out_valid=%0d in_ready=%0d diff=0x%02h", c, out_valid, in_ready, diff);
            end
            @(negedge clk);
            a = 8'h09; b = 8'h04; bin = 1'b0; out_ready = 1'b1;
            @(posedge clk); #1;
            check("bp handoff out_valid", 32'(out_valid), 32'd0);
            check("bp handoff in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            check("bp next accepted", 32'(in_ready), 32'd0);
            lat = 0;
            while (!out_valid && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            check("bp next latency", 32'(lat), 32'd8);
            check("bp next diff", 32'(diff), 32'h05);
            check("bp next bout", 32'(bout), 32'd0);
            $display("bp next op: a=0x09 b=0x04 -> diff=0x%02h bout=%0d lat=%0d", diff, bout, lat);
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of RUN
        begin
            int seen;
            @(negedge clk);
            a = 8'hAA; b = 8'h55; bin = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(posedge clk);
            @(posedge clk); #2;
            rst_n = 1'b0;
            #1;
            check("midrun reset out_valid", 32'(out_valid), 32'd0);
            check("midrun reset diff", 32'(diff), 32'd0);
            check("midrun reset bout", 32'(bout), 32'd0);
            check("midrun reset ovf", 32'(ovf), 32'd0);
            @(negedge clk);
            @(negedge clk); rst_n = 1'b1;
            seen = 0;
            for (int c = 0; c < 12; c++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("aborted op never valid", 32'(seen), 32'd0);
            $display("midrun reset: aborted op produced %0d valid cycles", seen);
            do_op('{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, "10-01 after reset"});
        end

        // WIDTH=1 instance: result one edge after acceptance
        for (int i = 0; i < 3; i++) begin
            int lat;
            @(negedge clk);
            w1_a = vecs1[i].a; w1_b = vecs1[i].b; w1_bin = vecs1[i].bin; w1_in_valid = 1'b1;
            @(posedge clk); #1;
            w1_in_valid = 1'b0;
            lat = 0;
            while (!w1_out_valid && lat < 10) begin
                @(posedge clk); #1;
                lat++;
            end
            check("w1 latency", 32'(lat), 32'd1);
            check("w1 diff", 32'(w1_diff), 32'(vecs1[i].diff));
            check("w1 bout", 32'(w1_bout), 32'(vecs1[i].bout));
            check("w1 ovf", 32'(w1_ovf), 32'(vecs1[i].ovf));
            $display("w1 op %0d: a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d ovf=%0d lat=%0d",
                     i, vecs1[i].a, vecs1[i].b, vecs1[i].bin, w1_diff, w1_bout, w1_ovf, lat);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
